bcd_add: RTL and testbench
==========================

BCD_ADD -- requirements
Module: bcd_add

Interface
REQ-001 Parameter PIPE_STAGES, default 1, SHALL set the register stages from input sample to output; the legal values are 1 and 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 in_valid  input  1  SHALL qualify a, b, cin for one operation per cycle.
REQ-005 a  input  4  SHALL be BCD addend digit (0-9).
REQ-006 b  input  4  SHALL be BCD addend digit (0-9).
REQ-007 cin  input  1  SHALL be the decimal carry-in (0 or 1).
REQ-008 out_valid  output  1  SHALL pulse high for one cycle per completed operation.
REQ-009 sum  output  4  SHALL be the BCD result digit (0-9).
REQ-010 cout  output  4  SHALL be the decimal carry-out, zero-extended (values 0 or 1), so it drives a next-digit cin (bit 0) or serves directly as a hundreds digit.
REQ-011 err  output  1  SHALL flag an operation with a non-BCD operand.

Function
REQ-012 Binary intermediate s = a + b + cin SHALL be computed at 5-bit width (no overflow).
REQ-013 If s <= 9, sum SHALL equal s[3:0] and cout SHALL equal 0.
REQ-014 If s >= 10, sum SHALL equal (s + 6) mod 16 and cout SHALL equal 1; range 10-19 maps to digits 0-9.
REQ-015 Results SHALL appear PIPE_STAGES cycles after the in_valid edge that sampled them, with out_valid high in that same cycle.
REQ-016 Back-to-back in_valid SHALL yield back-to-back out_valid with no bubbles; there is no back-pressure.
REQ-017 When out_valid is low, sum, cout and err SHALL hold the last valid result.
REQ-018 Inputs while in_valid is low SHALL be ignored.
REQ-019 Boundary cases: 9+9+1 gives sum 9, cout 1; 0+0+0 gives sum 0, cout 0; 9+0+1 gives sum 0, cout 1.

Reset
REQ-020 rst_n low SHALL immediately force out_valid, sum, cout and err to 0 and clear all pipeline stages, independent of clk.
REQ-021 An operation in flight when reset asserts SHALL be discarded; no out_valid after release until a new in_valid.
REQ-022 The first in_valid sampled on the first rising edge after rst_n deasserts SHALL be accepted.

Configuration
REQ-023 Macro BCD_ADD_ERR_CHECK_EN defined: err SHALL be 1 for an operation whose a > 9 or b > 9; in that case sum and cout SHALL be 0.
REQ-024 Macro BCD_ADD_ERR_CHECK_EN undefined: err SHALL be tied to 0, and non-BCD operands SHALL pass through REQ-012 to REQ-014 unchanged (result unspecified as BCD but deterministic).

Structure
REQ-025 Shared package bcd_pkg SHALL hold typedef bcd_digit_t (4-bit logic), constants BCD_MAX = 9 and BCD_ADJ = 6.
REQ-026 Combinational sub-module bcd_digit_add (a, b, cin to sum, cout, err) SHALL implement REQ-012 to REQ-014 and REQ-023.
REQ-027 bcd_add SHALL wrap the sub-module with the PIPE_STAGES valid/data pipeline.
REQ-028 Two instances SHALL cascade into a two-digit adder, with low-digit cout[0] to high-digit cin and high-digit cout as the hundreds digit.

Verification
REQ-029 Exhaustive sweep of a, b 0-9 and cin 0-1 with in_valid held high: every result SHALL match a decimal reference, and out_valid SHALL be continuous after PIPE_STAGES cycles.
REQ-030 a=5, b=4, cin=0: sum=9, cout=0; a=5, b=5, cin=0: sum=0, cout=1.
REQ-031 a=9, b=9, cin=1: sum=9, cout=1, err=0.
REQ-032 With BCD_ADD_ERR_CHECK_EN, a=12, b=3: err=1, sum=0, cout=0; without it, err=0.
REQ-033 rst_n pulsed low mid-pipeline with PIPE_STAGES=2: outputs SHALL be 0 immediately, and no out_valid SHALL appear for the discarded operation.
REQ-034 Cascaded pair with operands 99 + 99: hundreds digit 1, tens 9, units 8.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit adder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Largest legal BCD digit and the correction added when a binary sum exceeds it.
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_ADJ = 4'd6;

    // One digit result as carried through the pipeline.
    typedef struct packed {
        bcd_digit_t sum;
        logic       cout;
        logic       err;
    } bcd_result_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: binary add, then decimal correction.
// Optional operand check enabled by defining BCD_ADD_ERR_CHECK_EN.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout,
    output logic       err
);

    // Five bits hold 15 + 15 + 1 without overflow.
    logic [4:0] bin_sum;

    // Binary add, decimal adjust above 9, optional non-BCD operand flag.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        sum     = '0;
        cout    = 1'b0;
        err     = 1'b0;
        bin_sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};

        if (bin_sum > {1'b0, BCD_MAX}) begin
            // Adding 6 modulo 16 folds 10..19 onto 0..9.
            sum  = bin_sum[3:0] + BCD_ADJ;
            cout = 1'b1;
        end else begin
            sum  = bin_sum[3:0];
            cout = 1'b0;
        end

`ifdef BCD_ADD_ERR_CHECK_EN
        if ((a > BCD_MAX) || (b > BCD_MAX)) begin
            err  = 1'b1;
            sum  = '0;
            cout = 1'b0;
        end
`else
        err = 1'b0;
`endif
    end

endmodule

// File: rtl/bcd_add.sv
// Pipelined single-digit BCD adder with valid qualification.
// PIPE_STAGES (1 or 2) register stages from input sample to output.
// Outputs hold the last valid result while out_valid is low.
// Define BCD_ADD_ERR_CHECK_EN to flag non-BCD operands on err.
module bcd_add
    import bcd_pkg::*;
#(
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       out_valid,
    output logic [3:0] sum,
    output logic [3:0] cout,
    output logic       err
);

    bcd_result_t stage_in;
    logic        vld [PIPE_STAGES];
    bcd_result_t dat [PIPE_STAGES];

    bcd_digit_add u_digit (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (stage_in.sum),
        .cout (stage_in.cout),
        .err  (stage_in.err)
    );

    // Valid/data shift pipeline; data only advances alongside a valid token so the tail holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: pipeline data is cleared too, since outputs must read 0 during reset and in-flight work is dropped.
            for (int i = 0; i < PIPE_STAGES; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage reads the previous stage's old value.
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= stage_in;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[PIPE_STAGES-1];
    assign sum       = dat[PIPE_STAGES-1].sum;
    assign cout      = {3'b000, dat[PIPE_STAGES-1].cout};
    assign err       = dat[PIPE_STAGES-1].err;

endmodule

// File: tb/tb_bcd_add.sv
// Self-checking bench for bcd_add: PIPE_STAGES=1 and 2 side by side on shared
// stimulus with queue scoreboards, plus a cascaded two-digit pair.
module tb_bcd_add;

    typedef struct packed {
        logic [3:0] sum;
        logic [3:0] cout;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b;
    logic       cin;

    logic       v1, v2, e1, e2;
    logic [3:0] s1, s2, c1, c2;

    logic       lo_in_valid;
    logic [3:0] lo_a, lo_b, hi_a, hi_b;
    logic       lo_valid, lo_err, hi_valid, hi_err;
    logic [3:0] lo_sum, lo_cout, hi_sum, hi_cout;

    res_t q1[$];
    res_t q2[$];
    res_t last1, last2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_add #(.PIPE_STAGES(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(v1), .sum(s1), .cout(c1), .err(e1)
    );

    bcd_add #(.PIPE_STAGES(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(v2), .sum(s2), .cout(c2), .err(e2)
    );

    bcd_add #(.PIPE_STAGES(1)) u_lo (
        .clk(clk), .rst_n(rst_n), .in_valid(lo_in_valid), .a(lo_a), .b(lo_b), .cin(1'b0),
        .out_valid(lo_valid), .sum(lo_sum), .cout(lo_cout), .err(lo_err)
    );

    bcd_add #(.PIPE_STAGES(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .in_valid(lo_valid), .a(hi_a), .b(hi_b), .cin(lo_cout[0]),
        .out_valid(hi_valid), .sum(hi_sum), .cout(hi_cout), .err(hi_err)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference; non-BCD operands follow the documented binary-plus-6 rule.
    function automatic res_t model(input int ia, input int ib, input int ic);
        res_t r;
        int   t;
        t = ia + ib + ic;
        r = '0;
        if (ia > 9 || ib > 9) begin
`ifdef BCD_ADD_ERR_CHECK_EN
            r.err = 1'b1;
`else
            if (t >= 10) begin
                r.sum  = 4'((t + 6) % 16);
                r.cout = 4'd1;
            end else begin
                r.sum = 4'(t);
            end
`endif
        end else begin
            r.sum  = 4'(t % 10);
            r.cout = 4'(t / 10);
        end
        return r;
    endfunction

    task automatic drive(input int ia, input int ib, input int ic);
        res_t r;
        a        = 4'(ia);
        b        = 4'(ib);
        cin      = 1'(ic);
        in_valid = 1'b1;
        r        = model(ia, ib, ic);
        q1.push_back(r);
        q2.push_back(r);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a        = 4'd7;
        b        = 4'd8;
        cin      = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard for PIPE_STAGES=1: pop on out_valid, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (v1) begin
                if (q1.size() == 0) check("p1_spurious_valid", 12'(v1), 12'd0);
                else begin
                    last1 = q1.pop_front();
                    check("p1_result", 12'({s1, c1, e1}), 12'(last1));
                end
            end else begin
                check("p1_hold", 12'({s1, c1, e1}), 12'(last1));
            end
        end
    end

    // Scoreboard for PIPE_STAGES=2.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (v2) begin
                if (q2.size() == 0) check("p2_spurious_valid", 12'(v2), 12'd0);
                else begin
                    last2 = q2.pop_front();
                    check("p2_result", 12'({s2, c2, e2}), 12'(last2));
                end
            end else begin
                check("p2_hold", 12'({s2, c2, e2}), 12'(last2));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ta, tb_, exp_bcd;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        lo_in_valid = 1'b0;
        lo_a        = '0;
        lo_b        = '0;
        hi_a        = '0;
        hi_b        = '0;
        last1       = '0;
        last2       = '0;

        // Reset state.
        #1;
        check("reset_p1", 12'({v1, s1, c1, e1}), 12'd0);
        check("reset_p2", 12'({v2, s2, c2, e2}), 12'd0);

        // Release and offer an operation on the very first edge.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5, 4, 0);
        @(negedge clk); drive(5, 5, 0);
        @(negedge clk); drive(9, 9, 1);
        @(negedge clk); drive(0, 0, 0);
        @(negedge clk); drive(9, 0, 1);
        @(negedge clk); idle(3);

        // Non-BCD operand.
        drive(12, 3, 0);
        @(negedge clk); idle(3);

        // Exhaustive back-to-back sweep; out_valid must stay high after the latency.
        for (int i = 0; i < 200; i++) begin
            drive(i / 20, (i / 2) % 10, i % 2);
            if (i >= 1) check("p1_continuous", 12'(v1), 12'd1);
            if (i >= 2) check("p2_continuous", 12'(v2), 12'd1);
            @(negedge clk);
        end
        idle(4);
        check("queues_drained", 12'(q1.size() + q2.size()), 12'd0);

        // Reset while an operation sits inside the two-stage pipeline.
        drive(7, 8, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        last1 = '0;
        last2 = '0;
        in_valid = 1'b0;
        #1;
        check("midreset_p1", 12'({v1, s1, c1, e1}), 12'd0);
        check("midreset_p2", 12'({v2, s2, c2, e2}), 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p2_no_ghost_valid", 12'(v2), 12'd0);
        end

        // Cascaded two-digit adder: low digit result feeds high digit carry.
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin ta = 99; tb_ = 99; end
                1:       begin ta = 45; tb_ = 55; end
                default: begin ta = 12; tb_ = 34; end
            endcase
            lo_a        = 4'(ta % 10);
            lo_b        = 4'(tb_ % 10);
            hi_a        = 4'(ta / 10);
            hi_b        = 4'(tb_ / 10);
            lo_in_valid = 1'b1;
            @(negedge clk);
            lo_in_valid = 1'b0;
            @(negedge clk);
            check("cascade_valid", 12'(hi_valid), 12'd1);
            exp_bcd = ((ta + tb_) / 100) * 256 + (((ta + tb_) / 10) % 10) * 16 + (ta + tb_) % 10;
            check("cascade_digits", {hi_cout, hi_sum, lo_sum}, 12'(exp_bcd));
            @(negedge clk);
        end

        check("queues_empty_end", 12'(q1.size() + q2.size()), 12'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
